// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Result registers hold the last completed conversion for the display driver.
module bcd_seq_converter #(
  parameter int unsigned BIN_W       = 17,
  parameter int unsigned DIGITS      = 6,
  parameter int unsigned SHOW_DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_ovf
);

  localparam int unsigned SCR_W = DIGITS * 4 + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

  state_e              r_state;
  logic [SCR_W-1:0]    r_scratch;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_ovf;

  logic [SCR_W-1:0]    w_adj;
  logic [SCR_W-1:0]    w_shift;
  logic                w_ovf;

  // Per-nibble add-3 in 4-bit arithmetic; no carry crosses a digit boundary.
  always_comb begin
    w_adj = r_scratch;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_scratch[BIN_W + 4*d +: 4] >= 4'd5) begin
        w_adj[BIN_W + 4*d +: 4] = r_scratch[BIN_W + 4*d +: 4] + 4'd3;
      end
    end
    w_shift = w_adj << 1;
  end

  always_comb begin
    w_ovf = 1'b0;
    for (int unsigned d = SHOW_DIGITS; d < DIGITS; d++) begin
      w_ovf = w_ovf | (r_scratch[BIN_W + 4*d +: 4] != 4'd0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        // The edge leaving DONE is the first idle edge, so a held start restarts at once.
        StIdle, StDone: begin
          if (i_start) begin
            r_scratch <= {{(4*DIGITS){1'b0}}, i_bin};
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= StConvert;
          end else begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        StConvert: begin
          if (r_cnt == CNT_W'(BIN_W)) begin
            r_bcd   <= r_scratch[SCR_W-1 -: 4*DIGITS];
            r_ovf   <= w_ovf;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_scratch <= w_shift;
            r_cnt     <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_bcd;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed and randomized checks of bcd_seq_converter against hand values and a div/mod model.
module tb_bcd_seq_converter;

  localparam int unsigned BIN_W       = 17;
  localparam int unsigned DIGITS      = 6;
  localparam int unsigned SHOW_DIGITS = 4;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [BIN_W-1:0]    bin   = '0;
  logic                busy;
  logic                done;
  logic                ovf;
  logic [4*DIGITS-1:0] bcd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bcd_seq_converter #(
    .BIN_W       (BIN_W),
    .DIGITS      (DIGITS),
    .SHOW_DIGITS (SHOW_DIGITS)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_bin   (bin),
    .o_busy  (busy),
    .o_done  (done),
    .o_bcd   (bcd),
    .o_ovf   (ovf)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive start for exactly one edge (E0); returns #1 after E0.
  task automatic launch(input logic [BIN_W-1:0] v);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // lat = number of edges after the call until done is seen high; -1 on timeout.
  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit && lat < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) lat = k;
    end
  endtask

  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int d = 0; d < int'(DIGITS); d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  logic [BIN_W-1:0] dir_vals [3] = '{17'd9999, 17'd0, 17'd131071};
  logic [23:0]      dir_bcd  [3] = '{24'h009999, 24'h000000, 24'h131071};
  logic             dir_ovf  [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    int lat;
    int pulses;
    int unsigned v;
    logic bad_nib;

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_bcd",  32'(bcd),  0);
    check("reset_ovf",  32'(ovf),  0);
    rst_n = 1'b1;

    // First conversion: latency, busy framing and single-cycle done.
    launch(17'd12345);
    @(negedge clk);
    check("busy_after_e0", 32'(busy), 1);
    check("done_low_converting", 32'(done), 0);
    wait_done(40, lat);
    check("latency_12345", 32'(lat), 18);
    check("bcd_12345", 32'(bcd), 32'h012345);
    check("ovf_12345", 32'(ovf), 1);
    check("busy_in_done", 32'(busy), 1);
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("busy_drops", 32'(busy), 0);

    for (int i = 0; i < 3; i++) begin
      launch(dir_vals[i]);
      wait_done(40, lat);
      check($sformatf("latency_%0d", dir_vals[i]), 32'(lat), 18);
      check($sformatf("bcd_%0d", dir_vals[i]), 32'(bcd), 32'(dir_bcd[i]));
      check($sformatf("ovf_%0d", dir_vals[i]), 32'(ovf), 32'(dir_ovf[i]));
    end

    // Abandon a conversion of 500 at cycle 9 with an asynchronous reset.
    launch(17'd500);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_bcd",  32'(bcd),  0);
    check("midrst_ovf",  32'(ovf),  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 0);
    check("midrst_bcd_held", 32'(bcd), 0);
    launch(17'd500);
    wait_done(40, lat);
    check("latency_500", 32'(lat), 18);
    check("bcd_500", 32'(bcd), 32'h000500);

    // A start pulse during CONVERT must be ignored, not queued.
    launch(17'd42);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    bin   = 17'd777;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(40, lat);
    check("latency_42_ignore", 32'(lat + 5), 18);
    check("bcd_42", 32'(bcd), 32'h000042);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) pulses++;
    end
    check("ignored_start_no_done", 32'(pulses), 0);
    check("bcd_42_held", 32'(bcd), 32'h000042);

    // Held start: back-to-back conversions every 19 cycles, bin stepping per accept.
    @(negedge clk);
    start = 1'b1;
    bin   = 17'd1;
    @(posedge clk);
    #1 bin = 17'd2;
    wait_done(40, lat);
    check("held_latency_1", 32'(lat), 18);
    check("held_bcd_1", 32'(bcd), 32'h000001);
    @(posedge clk);
    #1 bin = 17'd3;
    wait_done(40, lat);
    check("held_period_2", 32'(lat + 1), 19);
    check("held_bcd_2", 32'(bcd), 32'h000002);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(40, lat);
    check("held_period_3", 32'(lat + 1), 19);
    check("held_bcd_3", 32'(bcd), 32'h000003);
    @(posedge clk);
    @(negedge clk);
    check("held_busy_drops", 32'(busy), 0);

    // Random sweep against the divide/modulo model.
    for (int n = 0; n < 1000; n++) begin
      v = $urandom_range(0, 131071);
      launch(BIN_W'(v));
      wait_done(40, lat);
      check($sformatf("rnd_bcd_%0d", v), 32'(bcd), ref_bcd(v));
      check($sformatf("rnd_ovf_%0d", v), 32'(ovf), 32'(v > 9999));
      bad_nib = 1'b0;
      for (int d = 0; d < int'(DIGITS); d++) begin
        if (bcd[4*d +: 4] > 4'd9) bad_nib = 1'b1;
      end
      check($sformatf("rnd_nibble_range_%0d", v), 32'(bad_nib), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
